// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered LSU results onto the
// single register-file write port, cancelling buffered writes superseded by ALU writes.
`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef WORD
`define WORD 32
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [`REG_SIZE-1:0]   alu_rd,
  input  logic [`WORD-1:0]       alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [`REG_SIZE-1:0]   lsu_rd,
  input  logic [`WORD-1:0]       lsu_data,
  output logic [`REG_SIZE-1:0]   rf_waddr,
  output logic [`WORD-1:0]       rf_wdata,
  output logic                   rf_we,
  output logic                   alu_stall,
  output logic [`REG_COUNT-1:0]  pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]      r_valid;
  logic [`REG_SIZE-1:0]  r_rd   [DEPTH];
  logic [`WORD-1:0]      r_data [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [`REG_SIZE-1:0]  r_waddr;
  logic [`WORD-1:0]      r_wdata;
  logic                  r_we;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_v;
  logic                  w_alu_kill;
  logic                  w_push_v;
  logic [DEPTH-1:0]      w_valid_nxt;
  logic [`REG_COUNT-1:0] w_pending;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = lsu_valid && !w_full;
  assign w_head_v   = !w_empty && r_valid[r_head];
  // A killed head is discarded even while the ALU owns the write port.
  assign w_pop      = !w_empty && (alu_valid ? !r_valid[r_head] : 1'b1);
  assign w_alu_kill = alu_valid && (alu_rd != '0);
  assign w_push_v   = !(w_alu_kill && (lsu_rd == alu_rd));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_valid_nxt = r_valid;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alu_kill && (r_rd[i] == alu_rd)) w_valid_nxt[i] = 1'b0;
    end
    if (w_pop)  w_valid_nxt[r_head] = 1'b0;
    if (w_push) w_valid_nxt[r_tail] = w_push_v;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the payload array has no reset; a slot is only ever read while its
  // valid bit (which is reset) says it holds live data.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= lsu_rd;
      r_data[r_tail] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (alu_valid) begin
      r_we    <= (alu_rd != '0);
      r_waddr <= alu_rd;
      r_wdata <= alu_data;
    end else if (w_head_v) begin
      r_we    <= (r_rd[r_head] != '0);
      r_waddr <= r_rd[r_head];
      r_wdata <= r_data[r_head];
    end else begin
      r_we    <= 1'b0;
    end
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) w_pending[r_rd[i]] = 1'b1;
    end
    if (r_we) w_pending[r_waddr] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign lsu_ready = !w_full;
  assign alu_stall = w_full;
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign pending   = w_pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model feeds a
// scoreboard that a negedge monitor drains against the DUT outputs.
`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef WORD
`define WORD 32
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int RS    = `REG_SIZE;
  localparam int W     = `WORD;
  localparam int RC    = `REG_COUNT;

  logic          clk;
  logic          rst_n;
  logic          alu_valid;
  logic [RS-1:0] alu_rd;
  logic [W-1:0]  alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [RS-1:0] lsu_rd;
  logic [W-1:0]  lsu_data;
  logic [RS-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata;
  logic          rf_we;
  logic          alu_stall;
  logic [RC-1:0] pending;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_we     (rf_we),
    .alu_stall (alu_stall),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit            v;
    logic [RS-1:0] rd;
    logic [W-1:0]  d;
  } ent_t;

  typedef struct {
    int            tag;
    logic          we;
    logic [RS-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          rdy;
    logic          stall;
    logic [RC-1:0] pend;
  } st_t;

  typedef struct {
    logic [RS-1:0] a;
    logic [W-1:0]  d;
  } wr_t;

  ent_t mq[$];
  st_t  sq[$];
  wr_t  wq[$];

  logic          m_we;
  logic [RS-1:0] m_waddr;
  logic [W-1:0]  m_wdata;
  bit            m_accept;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Pending bitmap straight from its definition: any register with a live
  // buffered write or an in-flight output-register write.
  function automatic logic [RC-1:0] model_pending();
    logic [RC-1:0] p;
    p = '0;
    for (int r = 1; r < RC; r++) begin
      if (m_we && (m_waddr == RS'(r))) p[r] = 1'b1;
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].v && (mq[i].rd == RS'(r))) p[r] = 1'b1;
    end
    return p;
  endfunction

  // Drive one cycle of inputs, advance the model by one edge, queue expectations.
  task automatic step(input bit av, input logic [RS-1:0] ard, input logic [W-1:0] ad,
                      input bit lv, input logic [RS-1:0] lrd, input logic [W-1:0] ld);
    ent_t e;
    st_t  s;
    wr_t  w;
    bit   push;
    alu_valid = av;  alu_rd = ard;  alu_data = ad;
    lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ld;
    push = lv && (mq.size() != DEPTH);
    if (av) begin
      m_we = (ard != 0);  m_waddr = ard;  m_wdata = ad;
      if (mq.size() > 0 && !mq[0].v) void'(mq.pop_front());
      if (ard != 0)
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].rd == ard) mq[i].v = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.v) begin
        m_we = (e.rd != 0);  m_waddr = e.rd;  m_wdata = e.d;
      end else begin
        m_we = 1'b0;
      end
    end else begin
      m_we = 1'b0;
    end
    if (push) begin
      e.v = !(av && ard != 0 && lrd == ard);
      e.rd = lrd;
      e.d = ld;
      mq.push_back(e);
    end
    m_accept = push;
    s.tag = cyc_cnt + 1;
    s.we = m_we;  s.waddr = m_waddr;  s.wdata = m_wdata;
    s.rdy = (mq.size() != DEPTH);
    s.stall = (mq.size() == DEPTH);
    s.pend = model_pending();
    sq.push_back(s);
    if (m_we) begin
      w.a = m_waddr;  w.d = m_wdata;
      wq.push_back(w);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0);
  endtask

  task automatic model_reset();
    mq.delete();
    sq.delete();
    wq.delete();
    m_we = 1'b0;  m_waddr = '0;  m_wdata = '0;
  endtask

  st_t mon_s;
  wr_t mon_w;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sq.size() > 0 && sq[0].tag <= cyc_cnt) begin
        mon_s = sq.pop_front();
        check("status_tag", 64'(mon_s.tag), 64'(cyc_cnt));
        check("rf_we", 64'(rf_we), 64'(mon_s.we));
        check("rf_waddr", 64'(rf_waddr), 64'(mon_s.waddr));
        check("rf_wdata", 64'(rf_wdata), 64'(mon_s.wdata));
        check("lsu_ready", 64'(lsu_ready), 64'(mon_s.rdy));
        check("alu_stall", 64'(alu_stall), 64'(mon_s.stall));
        check("pending", 64'(pending), 64'(mon_s.pend));
      end
      if (rf_we) begin
        check("write_expected", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) begin
          mon_w = wq.pop_front();
          check("write_addr_order", 64'(rf_waddr), 64'(mon_w.a));
          check("write_data_order", 64'(rf_wdata), 64'(mon_w.d));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"}, 64'(rf_we), 64'd0);
    check({tag, "_rf_waddr"}, 64'(rf_waddr), 64'd0);
    check({tag, "_rf_wdata"}, 64'(rf_wdata), 64'd0);
    check({tag, "_lsu_ready"}, 64'(lsu_ready), 64'd1);
    check({tag, "_alu_stall"}, 64'(alu_stall), 64'd0);
    check({tag, "_pending"}, 64'(pending), 64'd0);
  endtask

  bit            r_av, r_lv;
  logic [RS-1:0] r_ard, r_lrd;
  logic [W-1:0]  r_ad, r_ld;

  initial begin
    rst_n = 1'b0;
    alu_valid = 0;  alu_rd = '0;  alu_data = '0;
    lsu_valid = 0;  lsu_rd = '0;  lsu_data = '0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // ALU write rd=5 has latency 1 and sets pending[5] for one cycle.
    step(1, 5'd5, 32'h1234, 0, '0, '0);
    idle(2);

    // LSU results wait behind three ALU cycles, then drain in order.
    step(1, 5'd1, 32'h100, 1, 5'd3, 32'hAA);
    step(1, 5'd2, 32'h200, 1, 5'd4, 32'hBB);
    step(1, 5'd6, 32'h300, 0, '0, '0);
    idle(4);

    // A younger ALU write to r7 cancels the buffered LSU write to r7.
    step(0, '0, '0, 1, 5'd7, 32'h11);
    step(1, 5'd7, 32'h22, 0, '0, '0);
    idle(3);

    // Fill the FIFO while the ALU is busy, then hold the next LSU offer.
    for (int i = 0; i < DEPTH; i++)
      step(1, RS'(10 + i), W'(32'hA00 + i), 1, RS'(20 + i), W'(32'hB00 + i));
    check("full_lsu_ready", 64'(lsu_ready), 64'd0);
    check("full_alu_stall", 64'(alu_stall), 64'd1);
    step(0, '0, '0, 1, 5'd24, 32'h55);
    step(0, '0, '0, 1, 5'd24, 32'h55);
    idle(DEPTH + 2);

    // Register 0 is never written and never pending.
    step(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
    step(0, '0, '0, 1, 5'd0, 32'hCAFE);
    idle(3);

    // Same-cycle LSU push to the ALU's register is the older write.
    step(1, 5'd9, 32'h99, 1, 5'd9, 32'h98);
    idle(3);

    // Asynchronous reset with three entries buffered and a write in flight.
    step(1, 5'd11, 32'hD1, 1, 5'd3, 32'hE1);
    step(1, 5'd12, 32'hD2, 1, 5'd4, 32'hE2);
    step(1, 5'd13, 32'hD3, 1, 5'd6, 32'hE3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    alu_valid = 0;  lsu_valid = 0;
    model_reset();
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    idle(5);

    // Randomized traffic over a small register set to exercise kills.
    r_lv = 0;
    for (int n = 0; n < 800; n++) begin
      if (!r_lv) begin
        r_lv  = ($urandom_range(0, 99) < 55);
        r_lrd = RS'($urandom_range(0, 7));
        r_ld  = $urandom;
      end
      if (mq.size() == DEPTH) r_av = ($urandom_range(0, 9) == 0);
      else                    r_av = ($urandom_range(0, 99) < 45);
      r_ard = RS'($urandom_range(0, 7));
      r_ad  = $urandom;
      step(r_av, r_ard, r_ad, r_lv, r_lrd, r_ld);
      if (m_accept) r_lv = 0;
    end
    idle(DEPTH + 4);

    @(negedge clk);
    #1;
    check("writes_left", 64'(wq.size()), 64'd0);
    check("status_left", 64'(sq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute/memory stages and the general register file. It merges single-cycle ALU results with variable-latency load/store-unit (LSU) results onto the register file's single write port (write address, write data, write enable). It buffers LSU results in a small FIFO and cancels stale buffered writes that a younger ALU write supersedes. It also exports a pending-register bitmap so the hazard logic can stall decode on operands that have not yet been written.

## Interface
Parameters:
- DEPTH, 4, LSU result FIFO entries (power of two, ≥2)
- register-address, data and register-count widths come from the global `REG_SIZE`, `WORD` and `REG_COUNT` macros

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle (no backpressure; always accepted)
- alu_rd  in  REG_SIZE  ALU destination register
- alu_data  in  WORD  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  FIFO can accept; transfer when lsu_valid && lsu_ready at an edge
- lsu_rd  in  REG_SIZE  LSU destination register
- lsu_data  in  WORD  LSU result
- rf_waddr  out  REG_SIZE  register file write address (registered)
- rf_wdata  out  WORD  register file write data (registered)
- rf_we  out  1  register file write enable (registered)
- alu_stall  out  1  FIFO full; upstream must present a bubble (alu_valid=0) next cycle
- pending  out  REG_COUNT  bit r = a write to r is buffered or in the output register

## Operation
- FIFO entry = {valid, rd, data}; circular buffer with head/tail pointers wrapping modulo DEPTH; occupancy count 0..DEPTH.
- Reset: count=0, pointers=0, all entry valid bits 0, rf_we=0, rf_waddr=0, rf_wdata=0. Combinational outputs after reset: lsu_ready=1, alu_stall=0, pending=0.
- lsu_ready = (count != DEPTH). alu_stall = (count == DEPTH).
- Per-cycle selection at each edge, in priority order:
  1. alu_valid: output register loads {alu_rd, alu_data}. rf_we = (alu_rd != 0).
  2. Otherwise, if the FIFO head is valid: pop the head and load it into the output register. rf_we = (head.rd != 0).
  3. Otherwise rf_we = 0; rf_waddr and rf_wdata hold their values.
- Invalid (killed) head: popped in any cycle, including cycles the ALU wins. At most one pop per cycle. A killed head never drives rf_we.
- Kill rule: when alu_valid and alu_rd != 0, every valid FIFO entry with rd == alu_rd is cleared in the same edge.
- A same-cycle LSU push with lsu_rd == alu_rd is the older write. It is stored with valid=0 but still occupies a slot.
- Writes to register 0 are never issued. Entries with rd=0 are pushed normally and drain without a write.
- Push and pop in the same edge: count is unchanged. A push into an empty FIFO is not bypassed; the earliest pop is the following edge.
- pending[r] = OR over valid FIFO entries with rd==r, OR (rf_we && rf_waddr==r). pending[0] is always 0.
- Asynchronous reset mid-operation discards all buffered entries and the output register immediately.

## Timing
- ALU result sampled at edge N: rf_we/rf_waddr/rf_wdata valid for cycle N→N+1. The register file takes the write in that cycle, giving latency 1.
- LSU result pushed at edge N with FIFO empty and no ALU at N+1: written during cycle N+1→N+2, giving latency 2.
- Each ALU-occupied cycle adds one cycle of LSU latency. FIFO order is preserved among surviving entries.
- alu_stall is derived only from registered count, with no combinational path from inputs. Upstream bubble at edge N+1 after alu_stall is seen in cycle N guarantees a drain or discard at N+1.
- If alu_valid is asserted while alu_stall=1, the ALU still wins and the LSU keeps waiting. This is legal but starves the LSU.
- Backpressure does not drop LSU data: while lsu_ready=0, lsu_valid/rd/data must be held by the LSU.

## Test plan
- Reset, then ALU write rd=5, data=0x1234 at edge 1: cycle 1 shows rf_we=1, rf_waddr=5, rf_wdata=0x1234. pending[5]=1 for exactly that cycle.
- LSU pushes rd=3/0xAA, then rd=4/0xBB, while alu_valid is high for 3 cycles: no LSU write during ALU cycles. Then writes 3/0xAA and 4/0xBB in order on consecutive cycles.
- LSU pushes rd=7/0x11, then the ALU writes rd=7/0x22 before it drains: only 7/0x22 is written. The killed entry drains with rf_we=0, and pending[7] clears after the ALU write cycle.
- Fill the FIFO with DEPTH pushes while the ALU is busy: lsu_ready=0 and alu_stall=1 at count=DEPTH. The held lsu_valid is accepted the edge after one pop. No data is lost.
- ALU rd=0 and LSU rd=0 writes: rf_we stays 0, and pending stays 0 for all bits.
- Assert rst_n=0 with 3 entries buffered and rf_we=1: all outputs return to reset values immediately. After release, no stale write appears.
